// File: rtl/hamming_7_4_decoder.sv
// hamming_7_4_decoder: 2-stage streaming Hamming(7,4) SEC decoder with saturating corrected-word counter
module hamming_7_4_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_data,
  output logic             out_err,
  output logic [2:0]       out_syndrome,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] err_count
);
  logic       advance, s1_valid, inc;
  logic [6:0] s1_code, fixed;
  logic [2:0] s1_syn, syn;
  logic [7:0] flip;
  always_comb begin
    syn = {^{in_code[3], in_code[4], in_code[5], in_code[6]},
           ^{in_code[1], in_code[2], in_code[5], in_code[6]},
           ^{in_code[0], in_code[2], in_code[4], in_code[6]}};
    // one-hot at position s; bit 0 (s=0) is dropped so a clean word is untouched
    flip    = 8'b1 << s1_syn;
    fixed   = s1_code ^ flip[7:1];
    advance = !out_valid || out_ready;
    inc     = advance && s1_valid && s1_syn != 3'd0;
  end
  assign in_ready = advance && !rst;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_code      <= '0;
      s1_syn       <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_err      <= 1'b0;
      out_syndrome <= '0;
      err_count    <= '0;
    end else begin
      if (advance) begin
        s1_valid     <= in_valid;
        s1_code      <= in_valid ? in_code : s1_code;
        s1_syn       <= in_valid ? syn : s1_syn;
        out_valid    <= s1_valid;
        out_data     <= {fixed[6], fixed[5], fixed[4], fixed[2]};
        out_err      <= s1_syn != 3'd0;
        out_syndrome <= s1_syn;
      end
      err_count <= cnt_clr ? CNT_W'(inc) :
                   (inc && !(&err_count)) ? err_count + CNT_W'(1) : err_count;
    end
  end
endmodule

// File: tb/tb_hamming_7_4_decoder.sv
// tb_hamming_7_4_decoder: directed vectors checked against a brute-force nearest-codeword model
module tb_hamming_7_4_decoder;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1, cnt_clr = 0;
  logic [6:0] in_code = '0;
  logic in_ready, out_valid, out_err, in_ready2, out_valid2, out_err2;
  logic [3:0] out_data, out_data2;
  logic [2:0] out_syndrome, out_syndrome2;
  logic [15:0] err_count;
  logic [1:0] err_count2;

  typedef struct {logic [3:0] d; logic [2:0] s; logic e; logic ok;} exp_t;
  exp_t q[$];
  logic [3:0] got[$];
  int errors = 0, checks = 0, stalls = 0, exp_cnt = 0;
  logic prev_ov = 0, prev_fire = 0, prev_clr = 0;

  always #5 clk = ~clk;

  hamming_7_4_decoder dut (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .out_syndrome(out_syndrome), .cnt_clr(cnt_clr), .err_count(err_count));

  hamming_7_4_decoder #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .in_valid(in_valid),
    .in_ready(in_ready2), .in_code(in_code), .out_valid(out_valid2), .out_ready(out_ready),
    .out_data(out_data2), .out_err(out_err2), .out_syndrome(out_syndrome2), .cnt_clr(cnt_clr),
    .err_count(err_count2));

  task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    return {d[3], d[2], d[1], d[1]^d[2]^d[3], d[0], d[0]^d[2]^d[3], d[0]^d[1]^d[3]};
  endfunction

  // nearest codeword by search: the data word and single flipped position that explain the code
  function automatic exp_t model(input logic [6:0] c);
    exp_t r = '{d: 4'd0, s: 3'd0, e: 1'b0, ok: 1'b0};
    for (int d = 0; d < 16; d++)
      for (int p = 0; p < 8; p++) begin
        logic [6:0] f = (p == 0) ? 7'd0 : 7'(1) << (p - 1);
        if (!r.ok && (enc(4'(d)) ^ f) == c) r = '{d: 4'(d), s: 3'(p), e: p != 0, ok: 1'b1};
      end
    return r;
  endfunction

  always @(negedge clk) begin
    logic nw;
    if (rst) begin
      check("in_ready_rst", in_ready, 0);
      q.delete();
      exp_cnt = 0; prev_ov = 0; prev_fire = 0; prev_clr = 0;
    end else begin
      check("in_ready", in_ready, !out_valid || out_ready);
      check("in_ready_w2", in_ready2, !out_valid2 || out_ready);
      nw = out_valid && (!prev_ov || prev_fire);
      if (nw && q.size() == 0) check("unexpected_word", 1, 0);
      if (prev_clr) exp_cnt = 0;
      if (nw && q.size() > 0 && q[0].e) exp_cnt++;
      check("err_count", err_count, exp_cnt > 65535 ? 65535 : exp_cnt);
      check("err_count_w2", err_count2, exp_cnt > 3 ? 3 : exp_cnt);
      if (out_valid && q.size() > 0) begin
        check("model_ok", q[0].ok, 1);
        check("out_data", out_data, q[0].d);
        check("out_syndrome", out_syndrome, q[0].s);
        check("out_err", out_err, q[0].e);
      end
      if (out_valid2 && q.size() > 0) check("out_w2", {out_err2, out_syndrome2, out_data2}, {q[0].e, q[0].s, q[0].d});
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        if (q.size() > 0) void'(q.pop_front());
      end
      if (in_valid && in_ready) q.push_back(model(in_code));
      prev_ov = out_valid; prev_fire = out_valid && out_ready; prev_clr = cnt_clr;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [6:0] c);
    logic acc;
    int n = 0;
    in_valid = 1; in_code = c;
    do begin
      @(negedge clk); acc = in_ready; @(posedge clk); #1; n++;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", 0, 1);
    stalls += n - 1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 100) begin tick(1); n++; end
    check("drain_timeout", n < 100, 1);
  endtask

  initial begin
    tick(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_err", out_err, 0);
    check("rst_out_syndrome", out_syndrome, 0);
    check("rst_err_count", err_count, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 0; #1;
    check("in_ready_after_rst", in_ready, 1);
    send(7'b1010101);
    check("latency_not_yet", out_valid, 0);
    tick(1);
    check("clean_valid", out_valid, 1);
    check("clean_data", out_data, 4'b1011);
    check("clean_err", out_err, 0);
    check("clean_syn", out_syndrome, 3'b000);
    check("clean_cnt", err_count, 0);
    drain();
    send(7'b1000101);
    tick(1);
    check("single_data", out_data, 4'b1011);
    check("single_syn", out_syndrome, 3'b101);
    check("single_err", out_err, 1);
    check("single_cnt", err_count, 1);
    drain();
    cnt_clr = 1; tick(1); cnt_clr = 0;
    check("clr_alone", err_count, 0);
    check("clr_alone_w2", err_count2, 0);
    got.delete(); stalls = 0;
    for (int d = 0; d < 16; d++)
      for (int p = 0; p < 8; p++)
        send(enc(4'(d)) ^ ((p == 0) ? 7'd0 : 7'(1) << (p - 1)));
    drain();
    check("sweep_stalls", stalls, 0);
    check("sweep_count", got.size(), 128);
    for (int i = 0; i < 128 && i < got.size(); i++) check("sweep_data", got[i], i / 8);
    check("sweep_err_count", err_count, 112);
    check("sweep_err_count_w2", err_count2, 3);
    cnt_clr = 1; tick(1); cnt_clr = 0;
    for (int i = 0; i < 5; i++) send(enc(4'(i + 3)) ^ (7'(1) << i));
    drain();
    check("sat_w2", err_count2, 3);
    check("sat_w16", err_count, 5);
    send(enc(4'd6) ^ 7'b0100000);
    cnt_clr = 1; tick(1); cnt_clr = 0;
    check("clr_inc", err_count, 1);
    check("clr_inc_w2", err_count2, 1);
    drain();
    got.delete();
    fork
      begin
        send(7'b0000111); send(7'b1010101); send(7'b0011001);
      end
      begin
        int n = 0;
        while (!out_valid && n < 20) begin tick(1); n++; end
        out_ready = 0;
        repeat (5) begin
          @(negedge clk); check("in_ready_full", in_ready, 0);
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    drain();
    check("bp_count", got.size(), 3);
    if (got.size() == 3) begin
      check("bp_word0", got[0], 4'b0001);
      check("bp_word1", got[1], 4'b1011);
      check("bp_word2", got[2], 4'b0010);
    end
    got.delete();
    out_ready = 0;
    send(enc(4'd5));
    send(enc(4'd9) ^ 7'b0000100);
    tick(1);
    check("full_before_rst", out_valid, 1);
    rst = 1; tick(1); rst = 0;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_cnt", err_count, 0);
    check("rst_mid_cnt_w2", err_count2, 0);
    out_ready = 1;
    tick(5);
    check("rst_mid_no_words", got.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end
endmodule
